// File: rtl/display_page_sequencer_if.sv
// Bus between the display page sequencer and its host: page data and control in,
// registered segment drive and page status out.
interface display_page_sequencer_if #(
    parameter int DIGITS = 6,
    parameter int PAGES  = 8,
    parameter int SEL_W  = 8
);
    localparam int PAGE_W = $clog2(PAGES);

    logic                      Tick;
    logic [SEL_W-1:0]          Selector;
    logic                      AutoMode;
    logic [PAGES*DIGITS*7-1:0] PageData;
    logic [PAGES-1:0]          PageValid;
    logic [DIGITS-1:0]         BlinkMask;
    logic [DIGITS*7-1:0]       Hex;
    logic [PAGE_W-1:0]         ActivePage;
    logic                      PageChange;

    modport master (
        output Tick, Selector, AutoMode, PageData, PageValid, BlinkMask,
        input  Hex, ActivePage, PageChange
    );

    modport slave (
        input  Tick, Selector, AutoMode, PageData, PageValid, BlinkMask,
        output Hex, ActivePage, PageChange
    );
endinterface

// File: rtl/display_page_sequencer.sv
// Seven-segment page sequencer: manual or dwell-timed auto page selection with tick-based blink.
// Optional lamp test (all segments lit) is built when DISPLAY_PAGE_SEQUENCER_LAMP_TEST_EN is defined.
module display_page_sequencer #(
    parameter int DIGITS     = 6,
    parameter int PAGES      = 8,
    parameter int SEL_W      = 8,
    parameter int DWELL      = 200,
    parameter int BLINK_HALF = 50
) (
    input  logic Clock,
    input  logic Reset,
`ifdef DISPLAY_PAGE_SEQUENCER_LAMP_TEST_EN
    input  logic LampTest,
`endif
    display_page_sequencer_if.slave bus
);
    localparam int PAGE_W  = $clog2(PAGES);
    localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int HEX_W   = DIGITS * 7;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    localparam logic [0:0] ST_MANUAL = 1'b0;
    localparam logic [0:0] ST_AUTO   = 1'b1;

    logic [0:0]         state, state_nx;
    logic [DWELL_W-1:0] dwell_cnt, dwell_nx;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_nx;
    logic               blink_phase, phase_nx;
    logic [PAGE_W-1:0]  sel_page, manual_page, target;
    logic [HEX_W-1:0]   hex_nx;

    // First valid page strictly after cur (wrapping); cur itself if it is the only one; 0 if none.
    function automatic logic [PAGE_W-1:0] next_valid(input logic [PAGE_W-1:0] cur,
                                                     input logic [PAGES-1:0]  valid);
        logic [PAGE_W-1:0] found;
        logic              hit;
        int                p;
        found = '0;
        hit   = 1'b0;
        for (int i = 1; i <= PAGES; i++) begin
            p = (int'(cur) + i) % PAGES;
            if (!hit && valid[p]) begin
                found = PAGE_W'(p);
                hit   = 1'b1;
            end
        end
        return found;
    endfunction

    assign sel_page = PAGE_W'(bus.Selector);

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        manual_page = '0;
        if ((32'(bus.Selector) < 32'(PAGES)) && bus.PageValid[sel_page])
            manual_page = sel_page;
    end

    // In AUTO the held auto page is ActivePage itself; it is only ever loaded from target.
    always_comb begin
        state_nx = state;
        dwell_nx = dwell_cnt;
        target   = bus.ActivePage;
        if (!bus.AutoMode) begin
            state_nx = ST_MANUAL;
            target   = manual_page;
        end else if (state == ST_MANUAL) begin
            state_nx = ST_AUTO;
            dwell_nx = '0;
        end else if (!bus.PageValid[bus.ActivePage]) begin
            dwell_nx = '0;
            target   = next_valid(bus.ActivePage, bus.PageValid);
        end else if (bus.Tick) begin
            if (dwell_cnt == DWELL_LAST) begin
                dwell_nx = '0;
                target   = next_valid(bus.ActivePage, bus.PageValid);
            end else begin
                dwell_nx = dwell_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        blink_cnt_nx = blink_cnt;
        phase_nx     = blink_phase;
        if (bus.Tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nx = '0;
                phase_nx     = ~blink_phase;
            end else begin
                blink_cnt_nx = blink_cnt + 1'b1;
            end
        end
    end

    // Hex is built from the next page and next phase so it lands on the same edge as them.
    always_comb begin
        hex_nx = bus.PageData[int'(target) * HEX_W +: HEX_W];
        for (int d = 0; d < DIGITS; d++) begin
            if (phase_nx && bus.BlinkMask[d])
                hex_nx[d*7 +: 7] = 7'h7f;
        end
`ifdef DISPLAY_PAGE_SEQUENCER_LAMP_TEST_EN
        if (LampTest)
            hex_nx = '0;
`endif
    end

    always_ff @(posedge Clock) begin
        // NOTE: state registers use non-blocking assignments so all of them update together.
        if (Reset) begin
            state          <= ST_MANUAL;
            dwell_cnt      <= '0;
            blink_cnt      <= '0;
            blink_phase    <= 1'b0;
            bus.Hex        <= '1;
            bus.ActivePage <= '0;
            bus.PageChange <= 1'b0;
        end else begin
            state          <= state_nx;
            dwell_cnt      <= dwell_nx;
            blink_cnt      <= blink_cnt_nx;
            blink_phase    <= phase_nx;
            bus.Hex        <= hex_nx;
            bus.ActivePage <= target;
            bus.PageChange <= (target != bus.ActivePage);
        end
    end
endmodule

// File: tb/tb_display_page_sequencer.sv
// Self-checking bench for display_page_sequencer: directed scenarios then random stimulus,
// all outputs compared each cycle against a behavioural page/dwell/blink model.
module tb_display_page_sequencer;
    localparam int DIGITS     = 6;
    localparam int PAGES      = 8;
    localparam int SEL_W      = 8;
    localparam int DWELL      = 4;
    localparam int BLINK_HALF = 2;
    localparam int HEX_W      = DIGITS * 7;

    logic Clock;
    logic Reset;
`ifdef DISPLAY_PAGE_SEQUENCER_LAMP_TEST_EN
    logic lamp_test;
`endif

    display_page_sequencer_if #(.DIGITS(DIGITS), .PAGES(PAGES), .SEL_W(SEL_W)) bus ();

    display_page_sequencer #(
        .DIGITS(DIGITS), .PAGES(PAGES), .SEL_W(SEL_W), .DWELL(DWELL), .BLINK_HALF(BLINK_HALF)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
`ifdef DISPLAY_PAGE_SEQUENCER_LAMP_TEST_EN
        .LampTest(lamp_test),
`endif
        .bus(bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit             m_auto;
    int             m_page;
    int             m_dwell;
    int             m_ticks;
    logic [HEX_W-1:0] m_hex;
    logic           m_chg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_page(input int cur, input logic [PAGES-1:0] valid);
        for (int k = 1; k <= PAGES; k++)
            if (valid[(cur + k) % PAGES]) return (cur + k) % PAGES;
        return 0;
    endfunction

    function automatic logic [6:0] page_digit(input int p, input int d);
        logic [PAGES*DIGITS*7-1:0] pd;
        pd = bus.PageData;
        return pd[(p*DIGITS + d)*7 +: 7];
    endfunction

    // Expected outputs after the coming edge, from the inputs currently applied.
    task automatic model_step();
        int prev;
        int phase;
        if (Reset) begin
            m_auto  = 1'b0;
            m_page  = 0;
            m_dwell = 0;
            m_ticks = 0;
            m_hex   = '1;
            m_chg   = 1'b0;
            return;
        end
        prev = m_page;
        if (bus.Tick) m_ticks++;
        if (!bus.AutoMode) begin
            m_auto = 1'b0;
            if (int'(bus.Selector) < PAGES && bus.PageValid[int'(bus.Selector)])
                m_page = int'(bus.Selector);
            else
                m_page = 0;
        end else if (!m_auto) begin
            m_auto  = 1'b1;
            m_dwell = 0;
        end else if (!bus.PageValid[m_page]) begin
            m_dwell = 0;
            m_page  = next_page(m_page, bus.PageValid);
        end else if (bus.Tick) begin
            m_dwell++;
            if (m_dwell == DWELL) begin
                m_dwell = 0;
                m_page  = next_page(m_page, bus.PageValid);
            end
        end
        phase = (m_ticks / BLINK_HALF) % 2;
        for (int d = 0; d < DIGITS; d++)
            m_hex[d*7 +: 7] = (phase == 1 && bus.BlinkMask[d]) ? 7'h7f : page_digit(m_page, d);
`ifdef DISPLAY_PAGE_SEQUENCER_LAMP_TEST_EN
        if (lamp_test) m_hex = '0;
`endif
        m_chg = (m_page != prev);
    endtask

    // One clock: inputs are set at the preceding negedge, outputs sampled 1 after posedge.
    task automatic step(input logic t);
        bus.Tick = t;
        model_step();
        @(posedge Clock);
        #1;
        check("hex",  64'(bus.Hex),        64'(m_hex));
        check("page", 64'(bus.ActivePage), 64'(m_page));
        check("chg",  64'(bus.PageChange), 64'(m_chg));
        @(negedge Clock);
        bus.Tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            step(1'b0);
        end
    endtask

    task automatic randomize_pages();
        for (int p = 0; p < PAGES; p++)
            for (int d = 0; d < DIGITS; d++)
                bus.PageData[(p*DIGITS + d)*7 +: 7] = 7'($urandom);
    endtask

    initial begin
        Reset         = 1'b1;
        bus.Tick      = 1'b0;
        bus.Selector  = 8'd3;
        bus.AutoMode  = 1'b0;
        bus.PageValid = '1;
        bus.BlinkMask = '0;
`ifdef DISPLAY_PAGE_SEQUENCER_LAMP_TEST_EN
        lamp_test     = 1'b0;
`endif
        randomize_pages();
        @(negedge Clock);

        // Reset, then release with Selector = 3
        step(1'b0);
        step(1'b0);
        check("reset_hex", 64'(bus.Hex), {64{1'b1}} >> (64 - HEX_W));
        check("reset_page", 64'(bus.ActivePage), 64'd0);
        Reset = 1'b0;
        step(1'b0);
        check("release_page", 64'(bus.ActivePage), 64'd3);
        check("release_chg", 64'(bus.PageChange), 64'd1);
        step(1'b0);
        check("release_chg_once", 64'(bus.PageChange), 64'd0);

        // Out-of-range and invalid selectors
        bus.Selector = 8'd9;
        step(1'b0);
        check("sel9_page", 64'(bus.ActivePage), 64'd0);
        bus.Selector  = 8'd5;
        bus.PageValid = 8'b1101_1111;
        step(1'b0);
        check("sel5_invalid_page", 64'(bus.ActivePage), 64'd0);
        check("sel5_invalid_chg", 64'(bus.PageChange), 64'd0);
        bus.Selector = 8'd255;
        step(1'b0);
        bus.PageValid = 8'b1111_1110;
        bus.Selector  = 8'd0;
        step(1'b0);
        check("page0_fallback", 64'(bus.ActivePage), 64'd0);

        // Auto rotation from page 2 over pages {0,2,4,7}
        bus.PageValid = 8'b1001_0101;
        bus.Selector  = 8'd2;
        step(1'b0);
        bus.AutoMode = 1'b1;
        step(1'b0);
        ticks(4);
        check("auto_step1", 64'(bus.ActivePage), 64'd4);
        ticks(4);
        check("auto_step2", 64'(bus.ActivePage), 64'd7);
        ticks(4);
        check("auto_wrap", 64'(bus.ActivePage), 64'd0);
        ticks(4);
        check("auto_step4", 64'(bus.ActivePage), 64'd2);
        ticks(4);
        check("auto_back4", 64'(bus.ActivePage), 64'd4);

        // Invalidate the shown page: jump at once, dwell restarts
        bus.PageValid = 8'b1000_0101;
        step(1'b0);
        check("invalid_jump", 64'(bus.ActivePage), 64'd7);
        ticks(3);
        check("dwell_restart", 64'(bus.ActivePage), 64'd7);
        ticks(1);
        check("dwell_after", 64'(bus.ActivePage), 64'd0);

        // Single valid page: no advance, no pulse
        bus.PageValid = 8'b0000_0001;
        ticks(4);
        check("single_stay", 64'(bus.ActivePage), 64'd0);
        check("single_nochg", 64'(bus.PageChange), 64'd0);

        // Blink of digit 0 on manual page 1, counted from a fresh reset
        bus.AutoMode  = 1'b0;
        bus.PageValid = '1;
        bus.Selector  = 8'd1;
        bus.BlinkMask = 6'b000001;
        Reset = 1'b1;
        step(1'b0);
        Reset = 1'b0;
        step(1'b0);
        for (int t = 1; t <= 5; t++) begin
            step(1'b1);
            check("blink_d0", 64'(bus.Hex[6:0]), (t == 2 || t == 3) ? 64'h7f : 64'(page_digit(1, 0)));
            check("blink_d1", 64'(bus.Hex[13:7]), 64'(page_digit(1, 1)));
            step(1'b0);
        end

`ifdef DISPLAY_PAGE_SEQUENCER_LAMP_TEST_EN
        // Lamp test while rotating mid-blink
        bus.AutoMode  = 1'b1;
        bus.BlinkMask = '1;
        step(1'b0);
        lamp_test = 1'b1;
        step(1'b1);
        check("lamp_on", 64'(bus.Hex), 64'd0);
        ticks(8);
        lamp_test = 1'b0;
        step(1'b0);
        check("lamp_off_page", 64'(bus.ActivePage), 64'(m_page));
`endif

        // Randomized stimulus against the model
        for (int c = 0; c < 4000; c++) begin
            Reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 59) == 0) bus.AutoMode = ~bus.AutoMode;
            if ($urandom_range(0, 9) == 0)
                bus.Selector = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, PAGES - 1));
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus.PageValid = '0;
                    1:       bus.PageValid = 8'(1 << $urandom_range(0, PAGES - 1));
                    default: bus.PageValid = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 49) == 0) bus.BlinkMask = 6'($urandom);
            if ($urandom_range(0, 199) == 0) randomize_pages();
`ifdef DISPLAY_PAGE_SEQUENCER_LAMP_TEST_EN
            if ($urandom_range(0, 99) == 0) lamp_test = ~lamp_test;
`endif
            step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
